bloom_ctrl: RTL and testbench

Controller and owner of the Bloom filter bit array in the packet-match path. It arbitrates between a configuration port and a query port. The configuration port sets or clears single bits, or sweeps the whole array clear. The query port checks NUM_HASH hash indices against the array and returns one match bit per query. Hash lanes are time-multiplexed over the probe cycles, and the single match result is returned with a valid/ready handshake.

---
 rtl/bloom_pkg.sv | 23 ++
 rtl/bloom_bit_array.sv | 50 +++++
 rtl/bloom_ctrl.sv | 145 ++++++++++++++
 tb/tb_bloom_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bloom_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bloom_pkg : shared encodings and types for the Bloom filter block  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package bloom_pkg;

  localparam int HASH_W = 8;

  localparam logic [1:0] CFG_SET     = 2'b00;
  localparam logic [1:0] CFG_CLR     = 2'b01;
  localparam logic [1:0] CFG_CLR_ALL = 2'b10;
  localparam logic [1:0] CFG_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PROBE = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bloom_bit_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bloom_bit_array : Bloom bit store, 1-bit write, chunk clear,       |
// | LANES combinational reads (out-of-range reads 0)       rev 1.0     |
// +--------------------------------------------------------------------+
module bloom_bit_array
  import bloom_pkg::*;
#(
  parameter int NUM_BITS = 256,
  parameter int LANES    = 3,
  parameter int CLR_STEP = 32,
  localparam int NUM_CHUNKS = NUM_BITS / CLR_STEP,
  localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [HASH_W-1:0]         wr_idx,
  input  logic                      wr_val,
  input  logic                      clr_en,
  input  logic [CHUNK_W-1:0]        clr_chunk,
  input  logic [LANES*HASH_W-1:0]   rd_idx,
  output logic [LANES-1:0]          rd_bit
);

  logic [NUM_BITS-1:0] bits;

  // Indices at or above NUM_BITS match no bit, so such writes are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      bits <= '0;
    end else begin
      for (int i = 0; i < NUM_BITS; i++) begin
        if (clr_en && (CHUNK_W'(i / CLR_STEP) == clr_chunk)) begin
          bits[i] <= 1'b0;
        end else if (wr_en && (HASH_W'(i) == wr_idx)) begin
          bits[i] <= wr_val;
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_rd
    logic [HASH_W-1:0] idx;
    assign idx       = rd_idx[l*HASH_W +: HASH_W];
    assign rd_bit[l] = ({1'b0, idx} < (HASH_W+1)'(NUM_BITS)) ? bits[idx] : 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/bloom_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bloom_ctrl : Bloom filter controller (config/query arbitration,    |
// | lane-multiplexed probe). Option macro: BLOOM_CTRL_STATS_EN rev 1.0 |
// +--------------------------------------------------------------------+
module bloom_ctrl
  import bloom_pkg::*;
#(
  parameter int NUM_BITS = 256,
  parameter int NUM_HASH = 9,
  parameter int LANES    = 3,
  parameter int CLR_STEP = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       qry_valid_i,
  output logic                       qry_ready_o,
  input  logic [HASH_W*NUM_HASH-1:0] qry_hash_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic                       res_match_o,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic [1:0]                 cfg_op_i,
  input  logic [HASH_W-1:0]          cfg_idx_i,
  output logic                       busy_o
`ifdef BLOOM_CTRL_STATS_EN
  ,
  output logic [31:0]                qry_cnt_o,
  output logic [31:0]                hit_cnt_o
`endif
);

  localparam int PROBE_CYC  = NUM_HASH / LANES;
  localparam int CNT_W      = (PROBE_CYC > 1) ? $clog2(PROBE_CYC) : 1;
  localparam int NUM_CHUNKS = NUM_BITS / CLR_STEP;
  localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  state_t                     state;
  state_t                     state_nxt;
  logic [HASH_W*NUM_HASH-1:0] hash_q;
  logic                       acc;
  logic [CNT_W-1:0]           cnt;
  logic [CHUNK_W-1:0]         clr_ptr;
  logic                       wr_en;
  logic                       wr_val;
  logic [LANES-1:0]           rd_bit;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cfg_ready_o = 1'b0;
    qry_ready_o = 1'b0;
    wr_en       = 1'b0;
    wr_val      = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready_o = 1'b1;
        qry_ready_o = !cfg_valid_i;
        if (cfg_valid_i) begin
          case (cfg_op_i)
            CFG_SET:     begin wr_en = 1'b1; wr_val = 1'b1; end
            CFG_CLR:     wr_en = 1'b1;
            CFG_CLR_ALL: state_nxt = CLEAR;
            CFG_RSVD:    ;
            default:     ;
          endcase
        end else if (qry_valid_i) begin
          state_nxt = PROBE;
        end
      end
      CLEAR: if (clr_ptr == CHUNK_W'(NUM_CHUNKS - 1)) state_nxt = IDLE;
      PROBE: if (cnt == CNT_W'(PROBE_CYC - 1)) state_nxt = RESP;
      RESP:  if (res_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o      = (state != IDLE);
  assign res_valid_o = (state == RESP);
  assign res_match_o = (state == RESP) && acc;

  // The latched hashes shift down one lane group per probe cycle, so the
  // read ports always look at the low LANES indices.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hash_q  <= '0;
      acc     <= 1'b0;
      cnt     <= '0;
      clr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          clr_ptr <= '0;
          if (!cfg_valid_i && qry_valid_i) begin
            hash_q <= qry_hash_i;
            acc    <= 1'b1;
            cnt    <= '0;
          end
        end
        CLEAR: clr_ptr <= clr_ptr + 1'b1;
        PROBE: begin
          acc    <= acc & (&rd_bit);
          cnt    <= cnt + 1'b1;
          hash_q <= hash_q >> (LANES * HASH_W);
        end
        default: ;
      endcase
    end
  end

  bloom_bit_array #(
    .NUM_BITS (NUM_BITS),
    .LANES    (LANES),
    .CLR_STEP (CLR_STEP)
  ) u_array (
    .clk       (clk_i),
    .rst       (rst_i),
    .wr_en     (wr_en),
    .wr_idx    (cfg_idx_i),
    .wr_val    (wr_val),
    .clr_en    (state == CLEAR),
    .clr_chunk (clr_ptr),
    .rd_idx    (hash_q[LANES*HASH_W-1:0]),
    .rd_bit    (rd_bit)
  );

`ifdef BLOOM_CTRL_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      qry_cnt_o <= '0;
      hit_cnt_o <= '0;
    end else if (res_valid_o && res_ready_i) begin
      qry_cnt_o <= qry_cnt_o + 32'd1;
      if (acc) hit_cnt_o <= hit_cnt_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bloom_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bloom_ctrl : directed scoreboard bench for bloom_ctrl  rev 1.0  |
// +--------------------------------------------------------------------+
module tb_bloom_ctrl;
  import bloom_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        qry_valid = 1'b0;
  logic        qry_ready;
  logic [71:0] qry_hash = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_match;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_op = 2'b00;
  logic [7:0]  cfg_idx = '0;
  logic        busy;
`ifdef BLOOM_CTRL_STATS_EN
  logic [31:0] qry_cnt;
  logic [31:0] hit_cnt;
`endif

  int          total = 0;
  int          bad = 0;
  logic        exp_q[$];
  logic [255:0] mdl = '0;
  int          n_qry = 0;
  int          n_hit = 0;
  int          bl[9] = '{3, 17, 40, 66, 90, 111, 130, 200, 255};

  bloom_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .qry_valid_i (qry_valid),
    .qry_ready_o (qry_ready),
    .qry_hash_i  (qry_hash),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_match_o (res_match),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_op_i    (cfg_op),
    .cfg_idx_i   (cfg_idx),
    .busy_o      (busy)
`ifdef BLOOM_CTRL_STATS_EN
    ,
    .qry_cnt_o   (qry_cnt),
    .hit_cnt_o   (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mk(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5,
                                     input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic predict(input logic [71:0] h);
    logic m = 1'b1;
    for (int k = 0; k < 9; k++) m &= mdl[h[8*k +: 8]];
    return m;
  endfunction

  function automatic logic [71:0] bl_hash();
    return mk(bl[0], bl[1], bl[2], bl[3], bl[4], bl[5], bl[6], bl[7], bl[8]);
  endfunction

  task automatic cfg(input logic [1:0] op, input int idx);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_op    = op;
    cfg_idx   = 8'(idx);
    #1 chk("cfg_ready", cfg_ready, 1);
    @(posedge clk);
    case (op)
      CFG_SET:     mdl[idx] = 1'b1;
      CFG_CLR:     mdl[idx] = 1'b0;
      CFG_CLR_ALL: mdl = '0;
      default:     ;
    endcase
    #1 cfg_valid = 1'b0;
  endtask

  task automatic query(input logic [71:0] h);
    @(negedge clk);
    qry_valid = 1'b1;
    qry_hash  = h;
    #1;
    chk("qry_ready", qry_ready, 1);
    chk("idle_busy", busy, 0);
    @(posedge clk);
    exp_q.push_back(predict(h));
    #1 qry_valid = 1'b0;
  endtask

  task automatic result(input int hold);
    int   lat = 0;
    logic e = 1'bx;
    do begin
      @(negedge clk);
      lat++;
      chk("busy", busy, 1);
    end while (!res_valid && lat < 20);
    chk("res_valid", res_valid, 1);
    chk("latency", lat, 4);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("match", res_match, e);
    if (hold > 0) qry_valid = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_match", res_match, e);
      chk("hold_qry_ready", qry_ready, 0);
    end
    qry_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    n_qry++;
    if (e === 1'b1) n_hit++;
    #1 res_ready = 1'b0;
    chk("res_drop", res_valid, 0);
  endtask

  task automatic stats();
`ifdef BLOOM_CTRL_STATS_EN
    chk("qry_cnt", qry_cnt, n_qry);
    chk("hit_cnt", hit_cnt, n_hit);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_match", res_match, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_qry_ready", qry_ready, 1);
    stats();

    // empty array misses
    query(mk(0, 1, 2, 3, 4, 5, 6, 7, 8));
    result(0);

    foreach (bl[i]) cfg(CFG_SET, bl[i]);
    query(bl_hash());
    result(0);
    query(mk(bl[0], bl[1], bl[2], bl[3], bl[4], bl[5], bl[6], bl[7], 254));
    result(0);

    // simultaneous config and query: config wins, query follows
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_op    = CFG_SET;
    cfg_idx   = 8'd5;
    qry_valid = 1'b1;
    qry_hash  = mk(5, 5, 5, 5, 5, 5, 5, 5, 5);
    #1;
    chk("both_cfg_ready", cfg_ready, 1);
    chk("both_qry_ready", qry_ready, 0);
    @(posedge clk);
    mdl[5] = 1'b1;
    #1 cfg_valid = 1'b0;
    #1 chk("after_cfg_qry_ready", qry_ready, 1);
    @(posedge clk);
    exp_q.push_back(predict(qry_hash));
    #1 qry_valid = 1'b0;
    result(0);

    cfg(CFG_RSVD, 3);
    cfg(CFG_CLR, 255);
    query(bl_hash());
    result(0);
    cfg(CFG_SET, 255);

    query(bl_hash());
    result(10);
    stats();

    // clear-all with a query waiting behind it
    cfg(CFG_CLR_ALL, 0);
    qry_valid = 1'b1;
    qry_hash  = bl_hash();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("clr_cfg_ready", cfg_ready, 0);
      chk("clr_qry_ready", qry_ready, 0);
      chk("clr_busy", busy, 1);
    end
    @(negedge clk);
    chk("clr_done_cfg_ready", cfg_ready, 1);
    chk("clr_done_qry_ready", qry_ready, 1);
    @(posedge clk);
    exp_q.push_back(predict(qry_hash));
    #1 qry_valid = 1'b0;
    result(0);
    stats();

    // reset while probing drops the query and zeroes the array
    foreach (bl[i]) cfg(CFG_SET, bl[i]);
    query(bl_hash());
    @(negedge clk);
    chk("probe_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mdl = '0;
    exp_q.delete();
    n_qry = 0;
    n_hit = 0;
    repeat (8) begin
      @(negedge clk);
      chk("rst_no_resp", res_valid, 0);
      chk("rst_idle", busy, 0);
    end
    query(bl_hash());
    result(0);
    stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
